// File: rtl/mvm_stream_feeder.sv
// Memory-to-stream source for the matrix-vector multiplier input port, with a 2-entry prefetch FIFO.
// Optional matrix reload every reload_period products when MVM_FEEDER_MATRIX_RELOAD_EN is defined.
module mvm_stream_feeder #(
   parameter int unsigned K  = 8,
   parameter int unsigned DW = 14,
   parameter int unsigned AW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [15:0]   num_vecs,
`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
   input  logic [7:0]    reload_period,
`endif
   output logic          busy,
   output logic          done,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_new_matrix
);

   localparam int unsigned MW  = K * K;
   localparam int unsigned WCW = (MW > 1) ? $clog2(MW) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t          state;
   logic [WCW-1:0]  word_cnt;
   logic            mat_phase;
   logic [15:0]     prod;
   logic [15:0]     nv_r;
   logic [AW-1:0]   vec_base;
   logic            rd_vld;
   logic            rd_tag;
   logic [DW-1:0]   fifo_data [2];
   logic            fifo_tag  [2];
   logic            rd_ptr;
   logic            wr_ptr;
   logic [1:0]      count;
   logic            pop;
   logic            credit;
   logic            reload_next;

   assign out_valid      = (count != 2'd0);
   assign out_data       = fifo_data[rd_ptr];
   assign out_new_matrix = out_valid && fifo_tag[rd_ptr];
   assign pop            = out_valid && out_ready;

   // Slots still free once this cycle's returning word lands and the head leaves.
   assign credit    = ({1'b0, count} + 3'(rd_vld) - 3'(pop)) < 3'd2;
   assign mem_rd_en = (state == S_RUN) && credit;

`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
   logic [7:0] rel_cnt;
   logic       prod_end;

   assign reload_next = (reload_period != 8'd0) && (rel_cnt == reload_period - 8'd1);
   assign prod_end    = mem_rd_en && !mat_phase && (word_cnt == WCW'(K - 1));

   // rel_cnt tracks the current product index modulo reload_period.
   always_ff @(posedge clk) begin
      if (reset)
         rel_cnt <= '0;
      else if (state == S_IDLE && start)
         rel_cnt <= '0;
      else if (prod_end)
         rel_cnt <= reload_next ? 8'd0 : rel_cnt + 8'd1;
   end
`else
   assign reload_next = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= '0;
         word_cnt  <= '0;
         mat_phase <= 1'b0;
         prod      <= '0;
         nv_r      <= '0;
         vec_base  <= '0;
         rd_vld    <= 1'b0;
         rd_tag    <= 1'b0;
      end else begin
         done   <= 1'b0;
         rd_vld <= mem_rd_en;
         rd_tag <= mem_rd_en && mat_phase && (word_cnt == '0);
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  nv_r      <= num_vecs;
                  prod      <= '0;
                  mat_phase <= 1'b1;
                  word_cnt  <= '0;
                  mem_addr  <= '0;
                  vec_base  <= AW'(MW);
                  state     <= (num_vecs == 16'd0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (mem_rd_en) begin
                  if (mat_phase) begin
                     if (word_cnt == WCW'(MW - 1)) begin
                        mat_phase <= 1'b0;
                        word_cnt  <= '0;
                        mem_addr  <= vec_base;
                     end else begin
                        word_cnt <= word_cnt + WCW'(1);
                        mem_addr <= mem_addr + AW'(1);
                     end
                  end else if (word_cnt == WCW'(K - 1)) begin
                     word_cnt <= '0;
                     if (prod == nv_r - 16'd1) begin
                        state <= S_FLUSH;
                     end else begin
                        prod      <= prod + 16'd1;
                        vec_base  <= vec_base + AW'(K);
                        mat_phase <= reload_next;
                        mem_addr  <= reload_next ? '0 : vec_base + AW'(K);
                     end
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                     mem_addr <= mem_addr + AW'(1);
                  end
               end
            end
            S_FLUSH: begin
               // Exit on the cycle the last word is accepted so done lands two cycles after it.
               if (!rd_vld && (count == 2'd0 || (count == 2'd1 && pop)))
                  state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_tag[0]  <= 1'b0;
         fifo_tag[1]  <= 1'b0;
      end else begin
         if (rd_vld) begin
            fifo_data[wr_ptr] <= mem_rd_data;
            fifo_tag[wr_ptr]  <= rd_tag;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({rd_vld, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_stream_feeder.sv
// Scoreboard bench for mvm_stream_feeder: memory model, directed runs, decoupled output monitor.
`timescale 1ns/1ps
module tb_mvm_stream_feeder;

   localparam int K  = 8;
   localparam int DW = 14;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   num_vecs;
`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
   logic [7:0]    reload_period;
`endif
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_new_matrix;

   mvm_stream_feeder #(.K(K), .DW(DW), .AW(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .num_vecs       (num_vecs),
`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
      .reload_period  (reload_period),
`endif
      .busy           (busy),
      .done           (done),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rd_data    (mem_rd_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_new_matrix (out_new_matrix)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] exp_data [$];
   bit            exp_tag  [$];
   logic [AW-1:0] exp_addr [$];

   int words_rx, tags_rx, done_total, outstanding, max_out;
   bit ready_rnd = 1'b0;

   function automatic logic [DW-1:0] word_at(input int a);
      return DW'((a * 613) ^ 32'h1A5B);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Synchronous-read memory; garbage on the bus when no read was issued.
   always @(posedge clk)
      mem_rd_data <= mem_rd_en ? word_at(int'(mem_addr)) : DW'($urandom);

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   logic          stall_q = 1'b0;
   logic [DW-1:0] data_q;
   logic          tag_q;

   always @(negedge clk) begin
      if (reset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, data_q);
            chk("hold_tag", out_new_matrix, tag_q);
         end
         if (mem_rd_en) begin
            if (exp_addr.size() == 0) chk("extra_read", 1, 0);
            else chk("rd_addr", mem_addr, exp_addr.pop_front());
            outstanding++;
         end
         if (out_valid && out_ready) begin
            words_rx++;
            if (out_new_matrix) tags_rx++;
            if (exp_data.size() == 0) begin
               chk("extra_word", 1, 0);
            end else begin
               chk("word_data", out_data, exp_data.pop_front());
               chk("word_tag", out_new_matrix, exp_tag.pop_front());
            end
            outstanding--;
         end
         if (outstanding > max_out) max_out = outstanding;
         if (done) done_total++;
         stall_q = out_valid && !out_ready;
         data_q  = out_data;
         tag_q   = out_new_matrix;
      end
   end

   task automatic build(input int nv, input int rp);
      for (int p = 0; p < nv; p++) begin
         bit mat = (p == 0) || (rp != 0 && (p % rp) == 0);
         if (mat)
            for (int a = 0; a < K * K; a++) begin
               exp_addr.push_back(AW'(a));
               exp_data.push_back(word_at(a));
               exp_tag.push_back(a == 0);
            end
         for (int j = 0; j < K; j++) begin
            exp_addr.push_back(AW'(K * K + p * K + j));
            exp_data.push_back(word_at(K * K + p * K + j));
            exp_tag.push_back(1'b0);
         end
      end
   endtask

   task automatic run(input string tag, input int nv, input int rp, input bit rnd,
                      input int nwords, input int ntags);
      int first_v = -1, first_rd = -1, done_at = -1, vcnt = 0, last_hs = -1;
      int busy1 = 0, busy_done = 1, d0;
      build(nv, rp);
      words_rx = 0; tags_rx = 0; max_out = 0; outstanding = 0;
      ready_rnd = rnd;
      d0 = done_total;
      @(posedge clk); #1;
      start = 1'b1;
      num_vecs = 16'(nv);
`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
      reload_period = 8'(rp);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 4000 && done_at < 0; i++) begin
         @(negedge clk);
         if (i == 1) busy1 = busy;
         if (mem_rd_en && first_rd < 0) first_rd = i;
         if (out_valid && first_v < 0) first_v = i;
         if (out_valid) vcnt++;
         if (out_valid && out_ready) last_hs = i;
         if (done) begin done_at = i; busy_done = busy; end
         if (nv > 0 && i == 10) begin start = 1'b1; num_vecs = 16'd7; end
         if (i == 11) start = 1'b0;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_done_cycle"}, done_at, (nv == 0) ? 2 : last_hs + 2);
      chk({tag, "_done_pulses"}, done_total - d0, 1);
      chk({tag, "_busy_c1"}, busy1, 1);
      chk({tag, "_busy_at_done"}, busy_done, 0);
      chk({tag, "_words"}, words_rx, nwords);
      chk({tag, "_tags"}, tags_rx, ntags);
      chk({tag, "_leftover"}, exp_data.size() + exp_addr.size(), 0);
      chk({tag, "_credit_le2"}, (max_out <= 2), 1);
      chk({tag, "_first_rd"}, first_rd, (nv > 0) ? 1 : -1);
      chk({tag, "_first_valid"}, first_v, (nv > 0) ? 3 : -1);
      if (!rnd) begin
         chk({tag, "_valid_cycles"}, vcnt, nwords);
         if (nv > 0) chk({tag, "_last_hs"}, last_hs, 2 + nwords);
      end
      exp_data.delete(); exp_tag.delete(); exp_addr.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_tag"}, out_new_matrix, 0);
      chk({tag, "_rd_en"}, mem_rd_en, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      int d0, rd_seen;
      reset = 1'b1; start = 1'b0; num_vecs = '0;
`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
      reload_period = '0;
`endif
      done_total = 0; outstanding = 0; max_out = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_zero("reset");

      run("nv1", 1, 0, 1'b0, 72, 1);
      run("nv3", 3, 0, 1'b0, 88, 1);
      run("nv3_rnd", 3, 0, 1'b1, 88, 1);
      run("nv0", 0, 0, 1'b0, 0, 0);

      // Abort a 5-product run mid-stream.
      build(5, 0);
      ready_rnd = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; num_vecs = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1 reset = 1'b1;
      d0 = done_total;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_data.delete(); exp_tag.delete(); exp_addr.delete();
      outstanding = 0;
      @(negedge clk);
      chk_zero("midreset");
      rd_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_rd_en) rd_seen++;
      end
      chk("midreset_no_reads", rd_seen, 0);
      chk("midreset_no_done", done_total - d0, 0);

      run("after_reset", 1, 0, 1'b0, 72, 1);

`ifdef MVM_FEEDER_MATRIX_RELOAD_EN
      run("reload2", 4, 2, 1'b0, 160, 2);
      run("reload1_rnd", 2, 1, 1'b1, 144, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
